// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block sequencer and its loader.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StWait,
    StWrite,
    StFin
  } state_e;

  localparam word_t H0 = 32'h6a09e667;
  localparam word_t H1 = 32'hbb67ae85;
  localparam word_t H2 = 32'h3c6ef372;
  localparam word_t H3 = 32'ha54ff53a;
  localparam word_t H4 = 32'h510e527f;
  localparam word_t H5 = 32'h9b05688c;
  localparam word_t H6 = 32'h1f83d9ab;
  localparam word_t H7 = 32'h5be0cd19;

  // Element 0 is H0.
  localparam word_t [7:0] IV = {H7, H6, H5, H4, H3, H2, H1, H0};

endpackage

// File: rtl/sha256_block_loader.sv
// Fetches one 16-word message block; read data lands one cycle behind its address.
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BLK_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [BLK_W-1:0]  blk_i,
  input  word_t             rdata_i,
  output logic              busy_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o,
  output word_t [15:0]      block_o
);

  logic [4:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  word_t [15:0] buf_q, buf_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    buf_d  = buf_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      // Count 0 only issues an address; counts 1..16 capture the previous read.
      if (cnt_q != 5'd0) begin
        buf_d[4'(cnt_q - 5'd1)] = rdata_i;
      end
      if (cnt_q == 5'd16) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      buf_q  <= buf_d;
    end
  end

  assign addr_o  = base_i + ADDR_W'({blk_i, 4'b0000}) + ADDR_W'(cnt_q[3:0]);
  assign busy_o  = busy_q;
  assign last_o  = busy_q && (cnt_q == 5'd16);
  assign block_o = buf_q;

endmodule

// File: rtl/sha256_block_sequencer.sv
// Drives an external SHA-256 compression core over a padded multi-block message
// and writes the final digest back to memory.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BLK_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] message_addr_i,
  input  logic [ADDR_W-1:0] output_addr_i,
  input  logic [BLK_W-1:0]  num_blocks_i,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output word_t             mem_write_data_o,
  input  word_t             mem_read_data_i,
  output logic              core_start_o,
  input  logic              core_done_i,
  output word_t [15:0]      core_block_o,
  output word_t [7:0]       core_hash_o,
  input  word_t [7:0]       core_digest_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] msg_q, msg_d;
  logic [ADDR_W-1:0] out_q, out_d;
  logic [BLK_W-1:0]  nblk_q, nblk_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [2:0]        k_q, k_d;
  word_t [7:0]       h_q, h_d;

  logic              ld_start, ld_busy, ld_last;
  logic [ADDR_W-1:0] ld_addr;

  sha256_block_loader #(
    .ADDR_W (ADDR_W),
    .BLK_W  (BLK_W)
  ) u_loader (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (ld_start),
    .base_i  (msg_q),
    .blk_i   (blk_q),
    .rdata_i (mem_read_data_i),
    .busy_o  (ld_busy),
    .last_o  (ld_last),
    .addr_o  (ld_addr),
    .block_o (core_block_o)
  );

  always_comb begin
    state_d          = state_q;
    msg_d            = msg_q;
    out_d            = out_q;
    nblk_d           = nblk_q;
    blk_d            = blk_q;
    k_d              = k_q;
    h_d              = h_q;
    ld_start         = 1'b0;
    done_o           = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    core_start_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        h_d   = IV;
        blk_d = '0;
        k_d   = '0;
        // An idle core is required so a reset mid-run cannot overlap a live core.
        if (start_i && core_done_i) begin
          msg_d  = message_addr_i;
          out_d  = output_addr_i;
          nblk_d = num_blocks_i;
          if (num_blocks_i == '0) begin
            state_d = StWrite;
          end else begin
            state_d  = StLoad;
            ld_start = 1'b1;
          end
        end
      end
      StLoad: begin
        if (ld_busy) mem_addr_o = ld_addr;
        if (ld_last) state_d = StKick;
      end
      StKick: begin
        core_start_o = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        if (core_done_i) begin
          h_d   = core_digest_i;
          blk_d = blk_q + BLK_W'(1);
          if (({1'b0, blk_q} + (BLK_W + 1)'(1)) < {1'b0, nblk_q}) begin
            state_d  = StLoad;
            ld_start = 1'b1;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_we_o         = 1'b1;
        mem_addr_o       = out_q + ADDR_W'(k_q);
        mem_write_data_o = h_q[k_q];
        k_d              = k_q + 3'd1;
        if (k_q == 3'd7) state_d = StFin;
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      msg_q   <= '0;
      out_q   <= '0;
      nblk_q  <= '0;
      blk_q   <= '0;
      k_q     <= '0;
      h_q     <= IV;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      nblk_q  <= nblk_d;
      blk_q   <= blk_d;
      k_q     <= k_d;
      h_q     <= h_d;
    end
  end

  assign core_hash_o = h_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: memory and compression-core models plus a
// whole-message SHA-256 reference.
module tb_sha256_block_sequencer;

  localparam logic [7:0][31:0] IV_TB = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [7:0][31:0] ABC_DIG = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                          32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [7:0][31:0] NIST_DIG = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                           32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {
    logic [15:0]       ma;
    logic [15:0]       oa;
    logic [7:0]        n;
    logic [31:0][31:0] msg;
    logic [7:0][31:0]  exp;
    logic [31:0]       exp_cyc;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       message_addr = '0;
  logic [15:0]       output_addr = '0;
  logic [7:0]        num_blocks = '0;
  logic              done, mem_we, core_start, core_done;
  logic [15:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data = '0;
  logic [15:0][31:0] core_block;
  logic [7:0][31:0]  core_hash;
  logic [7:0][31:0]  core_digest = '0;

  logic [31:0] mem [65536];
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [31:0] tb_data = '0;

  int unsigned busy_cnt = 0;
  bit          force_busy = 1'b0;
  int          n_kick = 0, n_done = 0, n_wr = 0;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] addr_q [$];

  always #5 clk = ~clk;

  sha256_block_sequencer #(
    .ADDR_W (16),
    .BLK_W  (8)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_i          (start),
    .message_addr_i   (message_addr),
    .output_addr_i    (output_addr),
    .num_blocks_i     (num_blocks),
    .done_o           (done),
    .mem_addr_o       (mem_addr),
    .mem_we_o         (mem_we),
    .mem_write_data_o (mem_write_data),
    .mem_read_data_i  (mem_read_data),
    .core_start_o     (core_start),
    .core_done_i      (core_done),
    .core_block_o     (core_block),
    .core_hash_o      (core_hash),
    .core_digest_i    (core_digest)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression including the feed-forward addition.
  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] h,
                                                input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [7:0][31:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7] +
             (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
    r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
    return r;
  endfunction

  // Hash of an N-block message read straight out of the memory image.
  function automatic logic [7:0][31:0] ref_hash(input logic [15:0] ma, input int n);
    logic [7:0][31:0]  h;
    logic [15:0][31:0] m;
    h = IV_TB;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 16; i++) m[i] = mem[16'(ma + 16'(16 * b + i))];
      h = compress(h, m);
    end
    return h;
  endfunction

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  // Core model: leaves idle on the start edge, idle again 66 cycles later.
  assign core_done = (busy_cnt == 0) && !force_busy;
  always @(posedge clk) begin
    if (core_start && core_done) begin
      core_digest <= compress(core_hash, core_block);
      busy_cnt    <= 66;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (core_start) n_kick <= n_kick + 1;
    if (done) n_done <= n_done + 1;
    if (mem_we) n_wr <= n_wr + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " mem_we"}, 32'(mem_we), 32'd0);
    chk({nm, " core_start"}, 32'(core_start), 32'd0);
    chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, " mem_write_data"}, mem_write_data, 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("%s core_block[%0d]", nm, i), core_block[i], 0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s core_hash[%0d]", nm, i), core_hash[i], IV_TB[i]);
  endtask

  // Cycle 0 is the start cycle; returns the cycle in which done is seen, -1 on timeout.
  task automatic run(input logic [15:0] ma, input logic [15:0] oa, input logic [7:0] n,
                     input int ign_a, input int ign_b, output int cyc);
    addr_q.delete();
    cyc = -1;
    @(negedge clk);
    message_addr = ma; output_addr = oa; num_blocks = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      addr_q.push_back(mem_addr);
      if (done) begin
        start = 1'b0;
        cyc = c;
        break;
      end
      start = (c == ign_a) || (c == ign_b);
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [15:0] ma, input logic [15:0] oa,
                           input logic [7:0] n, input logic [7:0][31:0] exp,
                           input logic [31:0] exp_cyc, input int ign_a, input int ign_b);
    int cyc, k0, d0, w0;
    k0 = n_kick; d0 = n_done; w0 = n_wr;
    run(ma, oa, n, ign_a, ign_b, cyc);
    chk({nm, " done cycle"}, 32'(cyc), exp_cyc);
    @(negedge clk);
    #1;
    chk({nm, " done one cycle"}, 32'(done), 32'd0);
    chk({nm, " core_start count"}, 32'(n_kick - k0), 32'(n));
    chk({nm, " done count"}, 32'(n_done - d0), 32'd1);
    chk({nm, " write count"}, 32'(n_wr - w0), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s digest[%0d]", nm, k), mem[16'(oa + 16'(k))], exp[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    logic [7:0][31:0] exp;
    logic [15:0] ma, oa;
    logic [7:0]  n;
    int k0, d0, w0;

    vecs[0] = '0;
    vecs[0].ma = 16'h0000; vecs[0].oa = 16'h0100; vecs[0].n = 8'd1;
    vecs[0].msg[0] = 32'h61626380; vecs[0].msg[15] = 32'h00000018;
    vecs[0].exp = ABC_DIG; vecs[0].exp_cyc = 32'd94;

    vecs[1] = '0;
    vecs[1].ma = 16'h0040; vecs[1].oa = 16'h0110; vecs[1].n = 8'd2;
    for (int i = 0; i < 14; i++) vecs[1].msg[i] = 32'h61626364 + 32'(i) * 32'h01010101;
    vecs[1].msg[14] = 32'h80000000; vecs[1].msg[31] = 32'h000001c0;
    vecs[1].exp = NIST_DIG; vecs[1].exp_cyc = 32'd179;

    vecs[2] = '0;
    vecs[2].ma = 16'h0080; vecs[2].oa = 16'h0120; vecs[2].n = 8'd0;
    vecs[2].exp = IV_TB; vecs[2].exp_cyc = 32'd9;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 16 * int'(vecs[v].n); i++)
        poke(16'(vecs[v].ma + 16'(i)), vecs[v].msg[i]);
      run_check($sformatf("vec%0d", v), vecs[v].ma, vecs[v].oa, vecs[v].n, vecs[v].exp,
                vecs[v].exp_cyc, -1, -1);
    end

    // Starts during LOAD and WAIT must be ignored.
    run_check("ignored starts", 16'h0000, 16'h0130, 8'd1, ABC_DIG, 32'd94, 5, 40);

    // Start held in IDLE while the core reports busy.
    k0 = n_kick; d0 = n_done; w0 = n_wr;
    force_busy = 1'b1;
    @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0; force_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy-core start core_start count", 32'(n_kick - k0), 32'd0);
    chk("busy-core start done count", 32'(n_done - d0), 32'd0);
    chk("busy-core start write count", 32'(n_wr - w0), 32'd0);
    chk("busy-core start mem_addr", 32'(mem_addr), 32'd0);

    // Message spanning the top of the address space.
    for (int i = 0; i < 16; i++) poke(16'(16'hfff8 + 16'(i)), $urandom);
    exp = ref_hash(16'hfff8, 1);
    run_check("wrap", 16'hfff8, 16'h0200, 8'd1, exp, 32'd94, -1, -1);
    for (int j = 0; j < 16; j++)
      chk($sformatf("wrap read addr %0d", j), 32'(addr_q[j]), 32'(16'(16'hfff8 + 16'(j))));

    for (int r = 0; r < 5; r++) begin
      n  = 8'($urandom_range(3, 1));
      ma = 16'($urandom);
      oa = 16'($urandom);
      for (int i = 0; i < 16 * int'(n); i++) poke(16'(ma + 16'(i)), $urandom);
      exp = ref_hash(ma, int'(n));
      run_check($sformatf("rand%0d", r), ma, oa, n, exp, 32'(85 * int'(n) + 9), -1, -1);
    end

    // Reset in the middle of WAIT, with the core still busy.
    for (int i = 0; i < 16; i++) poke(16'(i), vecs[0].msg[i]);
    @(negedge clk);
    message_addr = 16'h0000; output_addr = 16'h0400; num_blocks = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid-run core busy", 32'(core_done), 32'd0);
    k0 = n_kick; w0 = n_wr; d0 = n_done;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid-WAIT reset");
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (core_done) break;
      @(negedge clk);
    end
    chk("core drained after reset", 32'(core_done), 32'd1);
    chk("post-reset core_start count", 32'(n_kick - k0), 32'd0);
    chk("post-reset write count", 32'(n_wr - w0), 32'd0);
    chk("post-reset done count", 32'(n_done - d0), 32'd0);
    run_check("after reset", 16'h0000, 16'h0400, 8'd1, ABC_DIG, 32'd94, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
